result_drain: RTL and testbench
===============================

Name: result_drain

Overview:
- Reader for the 13-bit result data SRAM. The control path fills that memory; this block empties it.
- On `start`, it issues `count` single-port reads from `base_addr` upward and streams the returned words out over a valid/ready interface.
- It drives a 1-port SRAM read interface with 1-cycle read latency, and holds a 2-entry output buffer so that backpressure never loses a word.

Parameters:
- ADDR_W, 16, SRAM address width.
- DATA_W, 13, SRAM word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  begin a drain; sampled only in IDLE.
- base_addr  input  ADDR_W  first address; captured on accepted start.
- count  input  ADDR_W  number of words to read; captured on accepted start.
- mem_addr  output  ADDR_W  SRAM address.
- mem_rd  output  1  SRAM read enable.
- mem_rd_data  input  DATA_W  SRAM read data; valid the cycle after the edge that sampled mem_rd=1.
- out_data  output  DATA_W  head word of the output buffer.
- out_valid  output  1  output buffer not empty.
- out_ready  input  1  consumer accepts; transfer occurs when out_valid & out_ready at a posedge.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at drain completion.

Behaviour:
- Reset (rst=0, asynchronous) drives all outputs and state to zero immediately:
  - state=IDLE, buffer flushed, pending flag cleared, issued/received counters = 0.
  - mem_rd=0, mem_addr=0, out_valid=0, out_data=0, busy=0, done=0.
  - Reset asserted mid-drain aborts the drain with no done pulse. An SRAM read already in flight is discarded.
- States: IDLE, READ, DRAIN, FIN.
- IDLE:
  - start=1 at a posedge captures base_addr and count and clears the counters.
  - Goes to READ if count!=0, else to FIN.
  - start is ignored in every other state.
- READ:
  - mem_addr = base_addr + issued, modulo 2^ADDR_W, so the address wraps from 0xFFFF to 0x0000.
  - mem_rd is combinational from registered state: mem_rd = (issued < count) & (occ + pending - pop < 2), where:
    - occ is the buffer occupancy (0..2);
    - pending=1 when a read was issued at the previous edge;
    - pop = out_valid & out_ready.
  - mem_rd=0 and mem_addr holds its last value outside READ.
  - Each edge with mem_rd=1 increments issued and sets pending.
  - Each edge with pending=1 writes mem_rd_data into the buffer tail and increments received.
- Read is not combined with write; the SRAM read port is used exclusively.
- Buffer:
  - 2-entry FIFO; out_data is the head.
  - Push and pop may occur in the same cycle, leaving occupancy unchanged.
  - Overflow is impossible by the credit rule above. The bench asserts that occ never exceeds 2.
- READ goes to DRAIN at the edge where issued reaches count.
- DRAIN goes to FIN at the edge where the last word is popped: received==count, occ becomes 0, pending=0.
- FIN: done=1 and busy=1 for exactly one cycle, then IDLE.
  - A start sampled in FIN is ignored.
- Latency:
  - start sampled at edge E0 gives mem_rd=1 in cycle E0+1.
  - out_valid rises in cycle E0+3.
  - With out_ready held high, throughput is sustained at 1 word/cycle, and done pulses 1 cycle after the last handshake.
- count=0: start sampled at E0 gives done=1 in cycle E0+1. No mem_rd and no out_valid occur.
- out_valid stays asserted and out_data stays stable until accepted (no retraction).
- The first out_data word equals mem[base_addr]; words are delivered strictly in address order.

Test Plan:
- Basic drain: preload mem[0x10..0x13] = 0x0001, 0x1FFF, 0x0AAA, 0x1555; start with base=0x10, count=4, out_ready=1. Required: the four words out in order on consecutive cycles starting 3 cycles after the start edge, then done exactly 1 cycle after the last handshake, then busy=0.
- Backpressure: same preload as the basic drain; out_ready toggles 1,0,0,1,0,1,1... Required:
  - no loss or duplication, the same 4 words in order;
  - out_data stable while out_valid=1 and out_ready=0;
  - mem_rd=0 whenever the buffer plus pending read is full.
- Zero count: start with count=0. Required: done pulses the next cycle; mem_rd and out_valid are never asserted.
- Address wrap: base=0xFFFE, count=4. Required: mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, with data matching those locations.
- Start while busy: a second start pulse with base=0x40 during the READ/DRAIN/FIN states of a 3-word drain. Required: ignored; only the 3 original words are delivered and a single done pulse occurs.
- Reset mid-drain: rst=0 asynchronously after 2 of 6 words. Required:
  - outputs clear immediately, with no done pulse;
  - after rst=1, a new start with base=0x20, count=2 delivers mem[0x20] and mem[0x21] cleanly.

Source files
------------

// File: rtl/result_drain_if.sv
// SRAM read port plus valid/ready result stream between the drain engine
// (master) and the memory/consumer side (slave).
interface result_drain_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 13
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr, mem_rd, out_data, out_valid,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd, out_data, out_valid,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/result_drain.sv
// Streams count words of the result SRAM, from base_addr upward, out through a
// 2-entry buffer; reads are issued only when the buffer has room for them.
module result_drain #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  result_drain_if.master    bus,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] received_q, received_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic              pending_q, pending_d;
  logic [1:0]        occ_q, occ_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];

  logic              pop;
  logic              push;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        credit_used;

  always_comb begin
    pop         = (occ_q != 2'd0) && bus.out_ready;
    push        = pending_q;
    rd_addr     = base_q + issued_q;
    // Words already buffered or in flight, after this cycle's pop, must leave a free slot.
    credit_used = {1'b0, occ_q} + {2'b00, pending_q} - {2'b00, pop};
    rd_en       = (state_q == READ) && (issued_q < count_q) && (credit_used < 3'd2);

    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    issued_d    = issued_q;
    received_d  = received_q;
    addr_hold_d = addr_hold_q;
    pending_d   = rd_en;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_d      = fifo_q;
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop};

    if (push) begin
      fifo_d[wr_ptr_q] = bus.mem_rd_data;
      wr_ptr_d         = ~wr_ptr_q;
      received_d       = received_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (rd_en) begin
      issued_d = issued_q + 1'b1;
    end
    if (state_q == READ) begin
      addr_hold_d = rd_addr;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = base_addr;
          count_d    = count;
          issued_d   = '0;
          received_d = '0;
          state_d    = (count != '0) ? READ : FIN;
        end
      end
      READ: begin
        if (rd_en && (issued_d == count_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((received_d == count_q) && (occ_d == 2'd0) && !pending_d) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      received_q  <= '0;
      addr_hold_q <= '0;
      pending_q   <= 1'b0;
      occ_q       <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      received_q  <= received_d;
      addr_hold_q <= addr_hold_d;
      pending_q   <= pending_d;
      occ_q       <= occ_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
    end
  end

  assign bus.mem_rd    = rd_en;
  assign bus.mem_addr  = (state_q == READ) ? rd_addr : addr_hold_q;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = fifo_q[rd_ptr_q];
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: SRAM model, per-scenario tasks and a
// per-cycle protocol monitor (buffer occupancy, credit, output stability).
module tb_result_drain;
  localparam int AW = 16;
  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] count;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  result_drain_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  result_drain #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sram [0:65535];

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rd_data <= sram[bus.mem_addr];
  end

  // Independent occupancy model driven only by observed handshakes and reads.
  int            occ_m = 0;
  int            pend_m = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    int pop_m;
    if (!rst) begin
      occ_m = 0; pend_m = 0; prev_stall = 1'b0;
    end else begin
      pop_m = (bus.out_valid && bus.out_ready) ? 1 : 0;
      checks++;
      if (bus.out_valid !== (occ_m != 0)) begin
        failures++;
        $display("FAIL mon_valid: out_valid=%0b model_occ=%0d", bus.out_valid, occ_m);
      end
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
          failures++;
          $display("FAIL mon_stable: valid=%0b data=%h required valid=1 data=%h",
                   bus.out_valid, bus.out_data, prev_data);
        end
      end
      if (occ_m + pend_m - pop_m >= 2) begin
        checks++;
        if (bus.mem_rd !== 1'b0) begin
          failures++;
          $display("FAIL mon_credit: mem_rd=%0b required 0 (occ=%0d pend=%0d)", bus.mem_rd, occ_m, pend_m);
        end
      end
      occ_m  = occ_m + pend_m - pop_m;
      pend_m = bus.mem_rd ? 1 : 0;
      if (occ_m > 2) begin
        checks++;
        failures++;
        $display("FAIL mon_overflow: occ=%0d required <=2", occ_m);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  logic [DW-1:0] got_q[$];
  int            got_cyc[$];
  logic [AW-1:0] addr_q[$];
  int            done_cyc, done_cnt, valid_cnt, rd_cnt, stall_cnt;
  logic          busy_after, timed_out;

  // Stimulus/collection: start a drain, then record per-cycle observations.
  task automatic drain(input logic [AW-1:0] b, input logic [AW-1:0] n,
                       input logic [31:0] rdy_pat, input logic [31:0] start_mask,
                       input int max_cyc);
    int k;
    got_q.delete(); got_cyc.delete(); addr_q.delete();
    done_cyc = -1; done_cnt = 0; valid_cnt = 0; rd_cnt = 0; stall_cnt = 0;
    busy_after = 1'bx; timed_out = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; count = n; bus.out_ready = rdy_pat[0];
    k = 0;
    while (1) begin
      @(posedge clk); #1;
      k++;
      if (k < 32 && start_mask[k]) begin
        start = 1'b1; base_addr = 16'h0040; count = 16'd3;
      end else begin
        start = 1'b0;
      end
      bus.out_ready = (k < 32) ? rdy_pat[k] : 1'b1;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data); got_cyc.push_back(k);
      end
      if (bus.mem_rd) begin rd_cnt++; addr_q.push_back(bus.mem_addr); end
      if (bus.out_valid) valid_cnt++;
      if (bus.out_valid && !bus.out_ready) stall_cnt++;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = k; end
      if (done_cyc >= 0 && k == done_cyc + 1) busy_after = busy;
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
      if (k >= max_cyc) begin timed_out = 1'b1; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; bus.out_ready = 1'b0;
    #3 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_rd, bus.out_valid, busy, done} !== 4'b0000 || bus.mem_addr !== '0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rd=%0b valid=%0b busy=%0b done=%0b addr=%h data=%h required all 0",
               bus.mem_rd, bus.out_valid, busy, done, bus.mem_addr, bus.out_data);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_w [4];
    exp_w[0] = 13'h0001; exp_w[1] = 13'h1FFF; exp_w[2] = 13'h0AAA; exp_w[3] = 13'h1555;
    drain(16'h0010, 16'd4, 32'hFFFF_FFFF, 32'h0, 60);
    checks++;
    if (timed_out || got_q.size() != 4) begin
      failures++; $display("FAIL basic_count: words=%0d required 4 (timeout=%0b)", got_q.size(), timed_out);
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_w[i] || got_cyc[i] != 3 + i) begin
        failures++;
        $display("FAIL basic_word%0d: got %h at cycle %0d required %h at cycle %0d", i, got_q[i], got_cyc[i], exp_w[i], 3 + i);
      end
    end
    checks++;
    if (done_cyc != 7 || done_cnt != 1 || busy_after !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: done_cycle=%0d pulses=%0d busy_after=%0b required 7 1 0", done_cyc, done_cnt, busy_after);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_w [4];
    int            exp_c [4];
    exp_w[0] = 13'h0001; exp_w[1] = 13'h1FFF; exp_w[2] = 13'h0AAA; exp_w[3] = 13'h1555;
    exp_c[0] = 4; exp_c[1] = 6; exp_c[2] = 7; exp_c[3] = 8;
    // ready per cycle from the start edge: 1,0,0,1,0,1,1,...
    drain(16'h0010, 16'd4, 32'hFFFF_FFD2, 32'h0, 60);
    checks++;
    if (timed_out || got_q.size() != 4) begin
      failures++; $display("FAIL bp_count: words=%0d required 4 (timeout=%0b)", got_q.size(), timed_out);
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_w[i] || got_cyc[i] != exp_c[i]) begin
        failures++;
        $display("FAIL bp_word%0d: got %h at cycle %0d required %h at cycle %0d", i, got_q[i], got_cyc[i], exp_w[i], exp_c[i]);
      end
    end
    checks++;
    if (done_cyc != 9 || done_cnt != 1 || stall_cnt != 2 || rd_cnt != 4) begin
      failures++;
      $display("FAIL bp_done: done_cycle=%0d pulses=%0d stalls=%0d reads=%0d required 9 1 2 4", done_cyc, done_cnt, stall_cnt, rd_cnt);
    end
  endtask

  task automatic test_zero_count();
    drain(16'h0070, 16'd0, 32'hFFFF_FFFF, 32'h0, 20);
    checks++;
    if (timed_out || done_cyc != 1 || done_cnt != 1 || busy_after !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done_cycle=%0d pulses=%0d busy_after=%0b required 1 1 0", done_cyc, done_cnt, busy_after);
    end
    checks++;
    if (rd_cnt != 0 || valid_cnt != 0) begin
      failures++; $display("FAIL zero_activity: reads=%0d valid_cycles=%0d required 0 0", rd_cnt, valid_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] exp_w [4];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    exp_w[0] = 13'h0123; exp_w[1] = 13'h1ABC; exp_w[2] = 13'h0F0F; exp_w[3] = 13'h1234;
    drain(16'hFFFE, 16'd4, 32'hFFFF_FFFF, 32'h0, 60);
    checks++;
    if (timed_out || addr_q.size() != 4 || got_q.size() != 4) begin
      failures++;
      $display("FAIL wrap_count: reads=%0d words=%0d required 4 4 (timeout=%0b)", addr_q.size(), got_q.size(), timed_out);
    end
    for (int i = 0; i < 4 && i < addr_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (addr_q[i] !== exp_a[i] || got_q[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL wrap_%0d: addr %h data %h required addr %h data %h", i, addr_q[i], got_q[i], exp_a[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [DW-1:0] exp_w [3];
    exp_w[0] = 13'h0111; exp_w[1] = 13'h0222; exp_w[2] = 13'h0333;
    // extra start (base 0x40) in READ (cycle 2), DRAIN (cycle 4) and FIN (cycle 6)
    drain(16'h0030, 16'd3, 32'hFFFF_FFFF, 32'h0000_0054, 60);
    checks++;
    if (timed_out || got_q.size() != 3 || rd_cnt != 3) begin
      failures++; $display("FAIL busy_count: words=%0d reads=%0d required 3 3", got_q.size(), rd_cnt);
    end
    for (int i = 0; i < 3 && i < got_q.size() && i < addr_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_w[i] || addr_q[i] !== 16'h0030 + 16'(i)) begin
        failures++;
        $display("FAIL busy_word%0d: addr %h data %h required addr %h data %h", i, addr_q[i], got_q[i], 16'h0030 + 16'(i), exp_w[i]);
      end
    end
    checks++;
    if (done_cyc != 6 || done_cnt != 1 || busy_after !== 1'b0) begin
      failures++;
      $display("FAIL busy_done: done_cycle=%0d pulses=%0d busy_after=%0b required 6 1 0", done_cyc, done_cnt, busy_after);
    end
  endtask

  task automatic test_reset_mid_drain();
    int   hs = 0;
    int   k  = 0;
    logic saw_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0050; count = 16'd6; bus.out_ready = 1'b1;
    while (hs < 2 && k < 20) begin
      @(posedge clk); #1 start = 1'b0; k++;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) hs++;
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (hs != 2 || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre: handshakes=%0d valid=%0b required 2 1", hs, bus.out_valid);
    end
    @(posedge clk); #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.mem_rd, bus.out_valid, busy, done} !== 4'b0000 || bus.mem_addr !== '0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL rstmid_clear: rd=%0b valid=%0b busy=%0b done=%0b addr=%h data=%h required all 0",
               bus.mem_rd, bus.out_valid, busy, done, bus.mem_addr, bus.out_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++; $display("FAIL rstmid_nodone: done pulse seen=%0b required 0", saw_done);
    end
    drain(16'h0020, 16'd2, 32'hFFFF_FFFF, 32'h0, 40);
    checks++;
    if (timed_out || got_q.size() != 2 || done_cnt != 1) begin
      failures++; $display("FAIL rstmid_restart: words=%0d pulses=%0d required 2 1", got_q.size(), done_cnt);
    end else begin
      checks++;
      if (got_q[0] !== 13'h0321 || got_q[1] !== 13'h1CDE) begin
        failures++; $display("FAIL rstmid_data: got %h %h required 0321 1cde", got_q[0], got_q[1]);
      end
    end
  endtask

  initial begin
    sram[16'h0010] = 13'h0001; sram[16'h0011] = 13'h1FFF;
    sram[16'h0012] = 13'h0AAA; sram[16'h0013] = 13'h1555;
    sram[16'h0020] = 13'h0321; sram[16'h0021] = 13'h1CDE;
    sram[16'h0030] = 13'h0111; sram[16'h0031] = 13'h0222; sram[16'h0032] = 13'h0333;
    sram[16'h0040] = 13'h1EEE; sram[16'h0041] = 13'h1DDD; sram[16'h0042] = 13'h1CCC;
    for (int i = 0; i < 6; i++) sram[16'h0050 + 16'(i)] = 13'h0A00 + 13'(i);
    sram[16'hFFFE] = 13'h0123; sram[16'hFFFF] = 13'h1ABC;
    sram[16'h0000] = 13'h0F0F; sram[16'h0001] = 13'h1234;
    bus.mem_rd_data = '0;

    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_addr_wrap();
    test_start_while_busy();
    test_reset_mid_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
